fwd_operand_unit: RTL and testbench

FWD_OPERAND_UNIT -- requirements
Module: fwd_operand_unit

---
 rtl/fwd_operand_unit.sv | 162 ++++++++++++++++
 tb/tb_fwd_operand_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_operand_unit.sv
// Operand forwarding and ID->EX register for a 5-stage RISC-V pipeline.
// Resolves EX/MEM, MEM/WB and one-deep writeback history bypasses, stalls on load-use.
module fwd_operand_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs1,
   input  logic [ADDR_W-1:0] id_rs2,
   input  logic [DATA_W-1:0] id_rf1,
   input  logic [DATA_W-1:0] id_rf2,
   input  logic              exmem_wr_en,
   input  logic              exmem_is_load,
   input  logic [ADDR_W-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_alu,
   input  logic              memwb_wr_en,
   input  logic [ADDR_W-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_data,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic [1:0]        ex_sel1,
   output logic [1:0]        ex_sel2,
   output logic              id_stall,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   localparam logic [1:0] SEL_RF = 2'b00;
   localparam logic [1:0] SEL_EX = 2'b01;
   localparam logic [1:0] SEL_WB = 2'b10;
   localparam logic [1:0] SEL_HI = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e              state_q, state_d;
   logic                hist_valid_q, hist_valid_d;
   logic [ADDR_W-1:0]   hist_rd_q, hist_rd_d;
   logic [DATA_W-1:0]   hist_data_q, hist_data_d;
   logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d;
   logic [1:0]          sel1_q, sel1_d, sel2_q, sel2_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                ex1, wb1, hi1, ex2, wb2, hi2;
   logic [DATA_W-1:0]   fwd1, fwd2;
   logic [1:0]          fsel1, fsel2;
   logic                load_use, bp_hold, accept;

   always_comb begin
      ex1 = exmem_wr_en && (exmem_rd == id_rs1) && (id_rs1 != '0);
      wb1 = memwb_wr_en && (memwb_rd == id_rs1) && (id_rs1 != '0);
      hi1 = hist_valid_q && (hist_rd_q == id_rs1) && (id_rs1 != '0);
      ex2 = exmem_wr_en && (exmem_rd == id_rs2) && (id_rs2 != '0);
      wb2 = memwb_wr_en && (memwb_rd == id_rs2) && (id_rs2 != '0);
      hi2 = hist_valid_q && (hist_rd_q == id_rs2) && (id_rs2 != '0);
   end

   // Fixed priority: youngest producer wins.
   always_comb begin
      fsel1 = SEL_RF;
      fwd1  = id_rf1;
      if (ex1) begin
         fsel1 = SEL_EX;
         fwd1  = exmem_alu;
      end else if (wb1) begin
         fsel1 = SEL_WB;
         fwd1  = memwb_data;
      end else if (hi1) begin
         fsel1 = SEL_HI;
         fwd1  = hist_data_q;
      end
   end

   always_comb begin
      fsel2 = SEL_RF;
      fwd2  = id_rf2;
      if (ex2) begin
         fsel2 = SEL_EX;
         fwd2  = exmem_alu;
      end else if (wb2) begin
         fsel2 = SEL_WB;
         fwd2  = memwb_data;
      end else if (hi2) begin
         fsel2 = SEL_HI;
         fwd2  = hist_data_q;
      end
   end

   always_comb begin
      load_use = id_valid && exmem_is_load && (ex1 || ex2);
      bp_hold  = ex_valid && !ex_ready && id_valid;
      id_stall = load_use || bp_hold;
      accept   = id_valid && !id_stall && (!ex_valid || ex_ready);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= EMPTY;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL: begin
            if (accept)        state_d = FULL;
            else if (ex_ready) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      ex_valid = (state_q == FULL);
   end

   always_comb begin
      op1_d        = accept ? fwd1 : op1_q;
      op2_d        = accept ? fwd2 : op2_q;
      sel1_d       = accept ? fsel1 : sel1_q;
      sel2_d       = accept ? fsel2 : sel2_q;
      hist_valid_d = memwb_wr_en;
      hist_rd_d    = memwb_wr_en ? memwb_rd : hist_rd_q;
      hist_data_d  = memwb_wr_en ? memwb_data : hist_data_q;
      cnt_d        = cnt_q;
      if (load_use && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op1_q        <= '0;
         op2_q        <= '0;
         sel1_q       <= SEL_RF;
         sel2_q       <= SEL_RF;
         hist_valid_q <= 1'b0;
         hist_rd_q    <= '0;
         hist_data_q  <= '0;
         cnt_q        <= '0;
      end else begin
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         sel1_q       <= sel1_d;
         sel2_q       <= sel2_d;
         hist_valid_q <= hist_valid_d;
         hist_rd_q    <= hist_rd_d;
         hist_data_q  <= hist_data_d;
         cnt_q        <= cnt_d;
      end
   end

   assign ex_op1    = op1_q;
   assign ex_op2    = op2_q;
   assign ex_sel1   = sel1_q;
   assign ex_sel2   = sel2_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_operand_unit.sv
// Bench for fwd_operand_unit: directed vector table, hand sequences, random vs reference model.
module tb_fwd_operand_unit;

   localparam int CMAX = 3;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2;
   logic [31:0] id_rf1, id_rf2;
   logic        exmem_wr_en, exmem_is_load;
   logic [4:0]  exmem_rd;
   logic [31:0] exmem_alu;
   logic        memwb_wr_en;
   logic [4:0]  memwb_rd;
   logic [31:0] memwb_data;
   logic        ex_ready;
   logic        ex_valid;
   logic [31:0] ex_op1, ex_op2;
   logic [1:0]  ex_sel1, ex_sel2;
   logic        id_stall;
   logic [1:0]  stall_cnt;

   int total = 0;
   int bad = 0;

   fwd_operand_unit #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rf1(id_rf1), .id_rf2(id_rf2),
      .exmem_wr_en(exmem_wr_en), .exmem_is_load(exmem_is_load),
      .exmem_rd(exmem_rd), .exmem_alu(exmem_alu),
      .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .ex_ready(ex_ready), .ex_valid(ex_valid),
      .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_sel1(ex_sel1), .ex_sel2(ex_sel2),
      .id_stall(id_stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // reference model state
   bit          m_v;
   logic [31:0] m_op1, m_op2;
   logic [1:0]  m_s1, m_s2;
   bit          h_v;
   logic [4:0]  h_rd;
   logic [31:0] h_d;
   int          m_cnt;

   typedef struct {
      bit          v;
      logic [4:0]  rs1, rs2;
      logic [31:0] rf1, rf2;
      bit          ex_we, ex_ld;
      logic [4:0]  ex_rd;
      logic [31:0] alu;
      bit          wb_we;
      logic [4:0]  wb_rd;
      logic [31:0] wb_d;
      bit          e_v;
      logic [31:0] e_op1, e_op2;
      logic [1:0]  e_s1, e_s2;
   } vec_t;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
      end
   endtask

   task automatic m_reset();
      m_v = 0; m_op1 = 0; m_op2 = 0; m_s1 = 0; m_s2 = 0;
      h_v = 0; h_rd = 0; h_d = 0; m_cnt = 0;
   endtask

   function automatic logic [33:0] pick(input logic [4:0] rs, input logic [31:0] rf);
      if (rs == 0) return {2'd0, rf};
      if (exmem_wr_en && exmem_rd == rs) return {2'd1, exmem_alu};
      if (memwb_wr_en && memwb_rd == rs) return {2'd2, memwb_data};
      if (h_v && h_rd == rs) return {2'd3, h_d};
      return {2'd0, rf};
   endfunction

   task automatic idle_in();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rf1 = 0; id_rf2 = 0;
      exmem_wr_en = 0; exmem_is_load = 0; exmem_rd = 0; exmem_alu = 0;
      memwb_wr_en = 0; memwb_rd = 0; memwb_data = 0; ex_ready = 1;
   endtask

   task automatic set_in(input vec_t t);
      id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2;
      id_rf1 = t.rf1; id_rf2 = t.rf2;
      exmem_wr_en = t.ex_we; exmem_is_load = t.ex_ld;
      exmem_rd = t.ex_rd; exmem_alu = t.alu;
      memwb_wr_en = t.wb_we; memwb_rd = t.wb_rd; memwb_data = t.wb_d;
      ex_ready = 1;
   endtask

   // One clock: check stall before the edge, advance the model, check registers after.
   task automatic tick();
      logic [33:0] p1, p2;
      bit lu, bp, acc;
      p1 = pick(id_rs1, id_rf1);
      p2 = pick(id_rs2, id_rf2);
      lu = id_valid && exmem_is_load && (p1[33:32] == 2'd1 || p2[33:32] == 2'd1);
      bp = m_v && !ex_ready && id_valid;
      acc = id_valid && !(lu || bp) && (!m_v || ex_ready);
      #1;
      chk("id_stall", id_stall, lu || bp);
      @(posedge clk);
      if (acc) begin
         m_v = 1;
         m_s1 = p1[33:32]; m_op1 = p1[31:0];
         m_s2 = p2[33:32]; m_op2 = p2[31:0];
      end else if (ex_ready) begin
         m_v = 0;
      end
      if (lu && m_cnt < CMAX) m_cnt++;
      h_v = memwb_wr_en;
      if (memwb_wr_en) begin
         h_rd = memwb_rd;
         h_d = memwb_data;
      end
      #1;
      chk("ex_valid", ex_valid, m_v);
      chk("ex_op1", ex_op1, m_op1);
      chk("ex_op2", ex_op2, m_op2);
      chk("ex_sel1", ex_sel1, m_s1);
      chk("ex_sel2", ex_sel2, m_s2);
      chk("stall_cnt", stall_cnt, m_cnt);
   endtask

   task automatic chk_reset_vals(input string n);
      chk({n, "_valid"}, ex_valid, 0);
      chk({n, "_op1"}, ex_op1, 0);
      chk({n, "_op2"}, ex_op2, 0);
      chk({n, "_sel"}, {ex_sel1, ex_sel2}, 0);
      chk({n, "_cnt"}, stall_cnt, 0);
      chk({n, "_stall"}, id_stall, 0);
   endtask

   initial begin
      vec_t tbl[7];
      tbl[0] = '{1, 3, 4, 32'h11, 32'h22, 0, 0, 0, 0, 0, 0, 0,
                 1, 32'h11, 32'h22, 2'd0, 2'd0};
      tbl[1] = '{1, 5, 4, 32'h99, 32'h22, 1, 0, 5, 32'hA, 1, 5, 32'hB,
                 1, 32'hA, 32'h22, 2'd1, 2'd0};
      tbl[2] = '{1, 5, 4, 32'h99, 32'h22, 0, 0, 5, 32'hA, 1, 5, 32'hC,
                 1, 32'hC, 32'h22, 2'd2, 2'd0};
      tbl[3] = '{1, 5, 4, 32'h99, 32'h22, 0, 0, 5, 32'hA, 0, 5, 32'hD,
                 1, 32'hC, 32'h22, 2'd3, 2'd0};
      tbl[4] = '{1, 0, 0, 32'h0, 32'h33, 1, 0, 0, 32'hFF, 0, 0, 0,
                 1, 32'h0, 32'h33, 2'd0, 2'd0};
      tbl[5] = '{1, 6, 8, 32'h1, 32'h2, 1, 0, 6, 32'h66, 1, 8, 32'h88,
                 1, 32'h66, 32'h88, 2'd1, 2'd2};
      tbl[6] = '{0, 6, 8, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0, 0,
                 0, 32'h66, 32'h88, 2'd1, 2'd2};

      idle_in();
      m_reset();
      reset_n = 0;
      #12;
      chk_reset_vals("por");
      reset_n = 1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         set_in(tbl[i]);
         tick();
         chk($sformatf("tbl%0d_v", i), ex_valid, tbl[i].e_v);
         chk($sformatf("tbl%0d_op1", i), ex_op1, tbl[i].e_op1);
         chk($sformatf("tbl%0d_op2", i), ex_op2, tbl[i].e_op2);
         chk($sformatf("tbl%0d_sel", i), {ex_sel1, ex_sel2}, {tbl[i].e_s1, tbl[i].e_s2});
      end

      // load-use from FULL: bubble, then forward from MEM/WB
      idle_in();
      id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rf1 = 32'h1; id_rf2 = 32'h2;
      tick();
      chk("lu_pre_full", ex_valid, 1);
      id_rs2 = 7;
      exmem_wr_en = 1; exmem_is_load = 1; exmem_rd = 7; exmem_alu = 32'h77;
      #1;
      chk("lu_stall", id_stall, 1);
      tick();
      chk("lu_bubble", ex_valid, 0);
      chk("lu_cnt", stall_cnt, 1);
      exmem_wr_en = 0; exmem_is_load = 0;
      memwb_wr_en = 1; memwb_rd = 7; memwb_data = 32'h55;
      tick();
      chk("lu_acc_v", ex_valid, 1);
      chk("lu_acc_op2", ex_op2, 32'h55);
      chk("lu_acc_sel2", ex_sel2, 2'd2);

      // backpressure: hold operands while sources change
      idle_in();
      id_valid = 1; id_rs1 = 3; id_rf1 = 32'h11;
      tick();
      chk("bp_op1", ex_op1, 32'h11);
      for (int k = 0; k < 3; k++) begin
         ex_ready = 0;
         id_rf1 = 32'h100 + k;
         exmem_wr_en = 1; exmem_rd = 3; exmem_alu = 32'h200 + k;
         #1;
         chk("bp_stall", id_stall, 1);
         tick();
         chk("bp_hold_op1", ex_op1, 32'h11);
         chk("bp_hold_sel1", ex_sel1, 2'd0);
         chk("bp_cnt", stall_cnt, 1);
      end
      idle_in();
      id_valid = 1; id_rs1 = 3; id_rf1 = 32'h44;
      tick();
      chk("bp_release_op1", ex_op1, 32'h44);

      // saturation with a 2-bit counter
      idle_in();
      id_valid = 1; id_rs1 = 9;
      exmem_wr_en = 1; exmem_is_load = 1; exmem_rd = 9;
      for (int k = 0; k < 5; k++) tick();
      chk("sat_cnt", stall_cnt, 3);

      // reset mid-FULL clears asynchronously
      idle_in();
      id_valid = 1; id_rs1 = 4; id_rs2 = 5; id_rf1 = 32'hAB; id_rf2 = 32'hCD;
      tick();
      chk("rst_pre_full", ex_valid, 1);
      reset_n = 0;
      #2;
      m_reset();
      chk_reset_vals("async_rst");
      @(negedge clk);
      reset_n = 1;
      @(posedge clk);
      #1;
      tick();
      chk("first_acc_v", ex_valid, 1);
      chk("first_acc_op1", ex_op1, 32'hAB);

      // random traffic against the model
      for (int n = 0; n < 500; n++) begin
         id_valid = ($urandom_range(0, 3) != 0);
         id_rs1 = 5'($urandom_range(0, 7));
         id_rs2 = 5'($urandom_range(0, 7));
         id_rf1 = $urandom;
         id_rf2 = $urandom;
         exmem_wr_en = $urandom_range(0, 1);
         exmem_is_load = ($urandom_range(0, 3) == 0);
         exmem_rd = 5'($urandom_range(0, 7));
         exmem_alu = $urandom;
         memwb_wr_en = $urandom_range(0, 1);
         memwb_rd = 5'($urandom_range(0, 7));
         memwb_data = $urandom;
         ex_ready = ($urandom_range(0, 9) < 7);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
